// File: rtl/serializer_piso_stream.sv
// Parallel-in/serial-out serializer with a one-word holding buffer,
// valid/ready intake and a programmable bit period.
module serializer_piso_stream #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int DIV_WIDTH  = 16,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIV_WIDTH-1:0]  bit_div,
    output logic                  srl_out,
    output logic                  srl_frame,
    output logic                  bit_strobe,
    output logic                  word_done
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_valid;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DIV_WIDTH-1:0]    cnt;
    logic [DIV_WIDTH-1:0]    period;
    logic [IW-1:0]           bidx;

    logic                    accept;
    logic                    bit_end;
    logic                    last_bit;
    logic                    word_end;
    logic                    load;
    logic [DIV_WIDTH-1:0]    div_eff;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    cur_bit;

    logic                    srl_nx;
    logic                    frame_nx;
    logic                    strobe_nx;
    logic                    done_nx;

    assign in_ready = ~hold_valid & ~rst;
    assign accept   = in_valid & in_ready;
    assign bit_end  = (cnt == period - DIV_WIDTH'(1));
    assign last_bit = (bidx == IW'(DATA_WIDTH - 1));
    assign word_end = (state == SHIFT) & bit_end & last_bit;
    assign load     = hold_valid & ((state == IDLE) | word_end);
    assign div_eff  = (bit_div == '0) ? DIV_WIDTH'(1) : bit_div;
    assign cur_bit  = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
    assign shifted  = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, shreg[DATA_WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (word_end && !hold_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; registered below so outputs trail internal state by one cycle
    always_comb begin
        srl_nx    = IDLE_LEVEL;
        frame_nx  = 1'b0;
        strobe_nx = 1'b0;
        done_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                srl_nx = IDLE_LEVEL;
            end
            SHIFT: begin
                srl_nx    = cur_bit;
                frame_nx  = 1'b1;
                strobe_nx = (cnt == '0);
                done_nx   = word_end;
            end
            default: srl_nx = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shreg      <= '0;
            cnt        <= '0;
            period     <= DIV_WIDTH'(1);
            bidx       <= '0;
        end else begin
            if (load) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end

            if (load) begin
                shreg  <= hold_data;
                period <= div_eff;
                cnt    <= '0;
                bidx   <= '0;
            end else if (state == SHIFT) begin
                if (bit_end) begin
                    cnt   <= '0;
                    bidx  <= bidx + IW'(1);
                    shreg <= shifted;
                end else begin
                    cnt <= cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            srl_out    <= IDLE_LEVEL;
            srl_frame  <= 1'b0;
            bit_strobe <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            srl_out    <= srl_nx;
            srl_frame  <= frame_nx;
            bit_strobe <= strobe_nx;
            word_done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_serializer_piso_stream.sv
// Scoreboard bench for serializer_piso_stream: LSB-first and MSB-first
// instances, expected per-cycle line values queued at word acceptance.
module tb_serializer_piso_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic [15:0] bit_div = 16'd1;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        rdy0, rdy1, s0, s1, f0, f1, b0, b1, d0, d1;

    int n_cmp = 0;
    int n_err = 0;
    int run0 = 0, run1 = 0, last0 = 0, last1 = 0, stb0 = 0;

    // entry = {srl_out, bit_strobe, word_done}
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    always #5 clk = ~clk;

    serializer_piso_stream #(
        .DATA_WIDTH(8), .MSB_FIRST(1'b0), .DIV_WIDTH(16), .IDLE_LEVEL(1'b1)
    ) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0),
        .in_ready(rdy0), .bit_div(bit_div), .srl_out(s0),
        .srl_frame(f0), .bit_strobe(b0), .word_done(d0)
    );

    serializer_piso_stream #(
        .DATA_WIDTH(8), .MSB_FIRST(1'b1), .DIV_WIDTH(16), .IDLE_LEVEL(1'b1)
    ) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1),
        .in_ready(rdy1), .bit_div(bit_div), .srl_out(s1),
        .srl_frame(f1), .bit_strobe(b1), .word_done(d1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int k, input logic s, input logic f,
                       input logic b, input logic d);
        logic [2:0] e;
        int sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (f === 1'b1) begin
            if (sz == 0) begin
                chk($sformatf("frame_unexpected%0d", k), 32'(f), 32'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("srl_out%0d", k), 32'(s), 32'(e[2]));
                chk($sformatf("bit_strobe%0d", k), 32'(b), 32'(e[1]));
                chk($sformatf("word_done%0d", k), 32'(d), 32'(e[0]));
            end
        end else begin
            chk($sformatf("idle_srl%0d", k), 32'(s), 32'd1);
            chk($sformatf("idle_strobe%0d", k), 32'(b), 32'd0);
            chk($sformatf("idle_done%0d", k), 32'(d), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, s0, f0, b0, d0);
            mon(1, s1, f1, b1, d1);
            if (b0 === 1'b1) stb0++;
            if (f0 === 1'b1) run0++;
            else if (run0 != 0) begin last0 = run0; run0 = 0; end
            if (f1 === 1'b1) run1++;
            else if (run1 != 0) begin last1 = run1; run1 = 0; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] w, input int p,
                        input bit msb);
        logic bv;
        for (int i = 0; i < 8; i++) begin
            bv = msb ? w[7-i] : w[i];
            for (int c = 0; c < p; c++) begin
                if (k == 0) q0.push_back({bv, c == 0, (i == 7) && (c == p - 1)});
                else        q1.push_back({bv, c == 0, (i == 7) && (c == p - 1)});
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] w);
        int n;
        logic r;
        n = 0;
        in_data = w;
        if (k == 0) v0 = 1'b1; else v1 = 1'b1;
        r = (k == 0) ? rdy0 : rdy1;
        while (r !== 1'b1 && n < 1000) begin
            tick();
            n++;
            r = (k == 0) ? rdy0 : rdy1;
        end
        chk("accept_wait", 32'(r), 32'd1);
        tick();
        if (k == 0) v0 = 1'b0; else v1 = 1'b0;
        in_data = ~w;
    endtask

    task automatic drain(input int k);
        int n;
        logic busy;
        n = 0;
        busy = (k == 0) ? (q0.size() != 0 || f0 !== 1'b0)
                        : (q1.size() != 0 || f1 !== 1'b0);
        while (busy && n < 2000) begin
            tick();
            n++;
            busy = (k == 0) ? (q0.size() != 0 || f0 !== 1'b0)
                            : (q1.size() != 0 || f1 !== 1'b0);
        end
        chk("drain_wait", 32'(busy), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        int n;
        int base;

        // reset and idle
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_rst0", 32'(rdy0), 32'd0);
            chk("ready_in_rst1", 32'(rdy1), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_srl0", 32'(s0), 32'd1);
        chk("rst_frame0", 32'(f0), 32'd0);
        chk("rst_strobe0", 32'(b0), 32'd0);
        chk("rst_done0", 32'(d0), 32'd0);
        chk("rst_srl1", 32'(s1), 32'd1);
        chk("rst_frame1", 32'(f1), 32'd0);
        chk("rst_ready0", 32'(rdy0), 32'd1);
        chk("rst_ready1", 32'(rdy1), 32'd1);
        repeat (10) tick();

        // single word, LSB first, one clock per bit
        bit_div = 16'd1;
        send(0, 8'hA5);
        push(0, 8'hA5, 1, 1'b0);
        @(negedge clk);
        chk("lat_frame_t0", 32'(f0), 32'd0);
        chk("ready_after_accept", 32'(rdy0), 32'd0);
        @(negedge clk);
        chk("lat_frame_t1", 32'(f0), 32'd0);
        chk("ready_after_transfer", 32'(rdy0), 32'd1);
        @(negedge clk);
        chk("lat_frame_t2", 32'(f0), 32'd1);
        drain(0);
        chk("a5_frame_len", 32'(last0), 32'd8);

        // MSB first, four clocks per bit
        bit_div = 16'd4;
        send(1, 8'h3C);
        push(1, 8'h3C, 4, 1'b1);
        drain(1);
        chk("3c_frame_len", 32'(last1), 32'd32);

        // back-to-back with valid held high
        bit_div = 16'd2;
        send(0, 8'hFF);
        push(0, 8'hFF, 2, 1'b0);
        send(0, 8'h00);
        push(0, 8'h00, 2, 1'b0);
        chk("ready_hold_full", 32'(rdy0), 32'd0);
        drain(0);
        chk("b2b_frame_len", 32'(last0), 32'd32);

        // zero divider, then a mid-word divider change
        bit_div = 16'd0;
        send(0, 8'h96);
        push(0, 8'h96, 1, 1'b0);
        tick();
        bit_div = 16'd2;
        send(0, 8'h3A);
        push(0, 8'h3A, 2, 1'b0);
        n = 0;
        while (rdy0 !== 1'b1 && n < 200) begin tick(); n++; end
        chk("div_ready_wait", 32'(rdy0), 32'd1);
        repeat (4) tick();
        bit_div = 16'd5;
        send(0, 8'hC5);
        push(0, 8'hC5, 5, 1'b0);
        drain(0);
        chk("div_frame_len", 32'(last0), 32'd64);

        // reset in the middle of a word with the holding buffer full
        bit_div = 16'd2;
        base = stb0;
        send(0, 8'h5A);
        push(0, 8'h5A, 2, 1'b0);
        send(0, 8'hC3);
        push(0, 8'hC3, 2, 1'b0);
        n = 0;
        while (stb0 < base + 4 && n < 200) begin tick(); n++; end
        chk("bit3_wait", 32'(stb0 - base), 32'd4);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("midrst_ready", 32'(rdy0), 32'd0);
        tick();
        @(negedge clk);
        chk("midrst_srl", 32'(s0), 32'd1);
        chk("midrst_frame", 32'(f0), 32'd0);
        chk("midrst_done", 32'(d0), 32'd0);
        chk("midrst_strobe", 32'(b0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run0 = 0;
        @(negedge clk);
        chk("postrst_ready", 32'(rdy0), 32'd1);
        repeat (20) tick();
        bit_div = 16'd1;
        send(0, 8'h81);
        push(0, 8'h81, 1, 1'b0);
        drain(0);
        chk("postrst_frame_len", 32'(last0), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
